// File: rtl/resource_granter_pkg.sv
// resource_granter_pkg: shared granter state type and one-hot helper
// Contents:
//   granter_state_t : granter FSM states GR_IDLE / GR_BUSY
//   OH_MAX          : widest one-hot vector oh_to_idx accepts
//   oh_to_idx       : index of the set bit in a one-hot vector (0 when zero)
package resource_granter_pkg;

    localparam int OH_MAX = 32;

    typedef enum logic {GR_IDLE, GR_BUSY} granter_state_t;

    // OR-ing the indices of set bits yields the index for one-hot input.
    function automatic int unsigned oh_to_idx(input logic [OH_MAX-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < OH_MAX; i++)
            if (oh[i]) idx = idx | unsigned'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, with wrap
// Ports:
//   req   [N-1:0]   : request vector
//   ptr   [IDW-1:0] : highest-priority index this cycle
//   sel   [IDW-1:0] : chosen index (valid only when valid=1)
//   valid           : any request present
module rr_arbiter
    import resource_granter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] sel,
    output logic           valid
);

    logic [N-1:0] upper;
    logic [N-1:0] pick;

    // Lowest set bit among requests >= ptr; if none, wrap to lowest overall.
    always_comb begin
        upper = req & ~((N'(1) << ptr) - N'(1));
        pick  = (|upper) ? (upper & (~upper + N'(1))) : (req & (~req + N'(1)));
        sel   = IDW'(oh_to_idx(OH_MAX'(pick)));
        valid = |req;
    end

endmodule

// File: rtl/resource_granter.sv
// resource_granter: round-robin req/grant/use/release granter with protocol-error flagging
// Optional feature macro: GRANTER_TIMEOUT_EN (forced revoke after MAX_HOLD BUSY cycles)
// Ports:
//   clk               : clock, all state on posedge
//   reset             : synchronous active-high reset
//   req      [N-1:0]  : req[i] high while requestor i waits
//   use_     [N-1:0]  : use_[i] high while requestor i uses the resource
//   release_ [N-1:0]  : release_[i] one-cycle pulse ending i's tenure
//   grant    [N-1:0]  : one-hot or zero level grant
//   owner    [IDW-1:0]: current / last owner index
//   busy              : high in BUSY
//   err               : sticky protocol-error flag
//   timeout           : sticky forced-revoke flag (0 without GRANTER_TIMEOUT_EN)
// use_/release_ carry a trailing underscore because use and release are reserved words.
module resource_granter
    import resource_granter_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   use_,
    input  logic [N-1:0]   release_,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           err,
    output logic           timeout
);

    granter_state_t state, state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic           sel_valid;
    logic           take;
    logic           rel_own;
    logic           expire;
    logic           bad;
    logic [N-1:0]   own_mask;
    logic [N-1:0]   touch;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req  (req),
        .ptr  (rr_ptr),
        .sel  (sel),
        .valid(sel_valid)
    );

    always_comb begin
        own_mask = N'(1) << owner;
        touch    = use_ | release_;
        take     = (state == GR_IDLE) && sel_valid;
        rel_own  = (state == GR_BUSY) && release_[owner];
        bad      = (state == GR_IDLE) ? |touch
                 : (|(touch & ~own_mask)) || (use_[owner] && release_[owner]);
        bad      = bad || ((release_ & (release_ - N'(1))) != '0);
        state_nx = take ? GR_BUSY : (rel_own || expire) ? GR_IDLE : state;
    end

`ifdef GRANTER_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    // Expiry on the MAX_HOLD-th BUSY cycle; a release in that cycle wins.
    assign expire = (state == GR_BUSY) && !rel_own && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset || state != GR_BUSY)
            hold_cnt <= '0;
        else if (hold_cnt != '1)
            hold_cnt <= hold_cnt + HOLD_W'(1);
        if (reset)
            timeout <= 1'b0;
        else if (expire)
            timeout <= 1'b1;
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= GR_IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= err | bad;
            if (take) begin
                grant  <= N'(1) << sel;
                owner  <= sel;
                rr_ptr <= (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);
            end else if (state_nx == GR_IDLE) begin
                grant <= '0;
            end
        end
    end

    assign busy = (state == GR_BUSY);

endmodule

// File: tb/tb_resource_granter.sv
// tb_resource_granter: randomized + directed scoreboard bench for resource_granter
module tb_resource_granter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
`ifdef GRANTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       err;
        logic       timeout;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] use_ = '0;
    logic [3:0] release_ = '0;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       err;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   order_q[$];

    // Reference model state: tenure status, owner, rotation pointer, sticky flags
    bit m_busy = 0;
    int m_owner = 0;
    int m_ptr = 0;
    bit m_err = 0;
    bit m_to = 0;
    int m_hold = 0;

    resource_granter #(.N(N), .IDW(2), .MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .use_    (use_),
        .release_(release_),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .err     (err),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock of the protocol rules, applied to the model.
    task automatic model_step(input logic [3:0] r, input logic [3:0] u, input logic [3:0] rl, input logic rs);
        bit bad;
        int nrel;
        bit found;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_err = 0; m_to = 0; m_hold = 0;
            return;
        end
        bad = 0;
        nrel = 0;
        for (int j = 0; j < N; j++) begin
            if ((u[j] || rl[j]) && !(m_busy && j == m_owner)) bad = 1;
            if (rl[j]) nrel++;
        end
        if (nrel > 1) bad = 1;
        if (m_busy && u[m_owner] && rl[m_owner]) bad = 1;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (!found && r[idx]) begin
                    found = 1;
                    m_owner = idx;
                end
            end
            if (found) begin
                m_busy = 1;
                m_ptr = (m_owner + 1) % N;
                m_hold = 0;
            end
        end else if (rl[m_owner]) begin
            m_busy = 0;
        end else if (TO_EN && m_hold + 1 >= MAX_HOLD) begin
            m_busy = 0;
            m_to = 1;
        end else begin
            m_hold++;
        end
        if (bad) m_err = 1;
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] u, input logic [3:0] rl, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r;
        use_ = u;
        release_ = rl;
        reset = rs;
        model_step(r, u, rl, rs);
        e.grant   = m_busy ? 4'(1 << m_owner) : 4'b0;
        e.owner   = 2'(m_owner);
        e.busy    = m_busy;
        e.err     = m_err;
        e.timeout = m_to;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] own_bit();
        return 4'(1 << m_owner);
    endfunction

    // Monitor: outputs are registered, so every cycle presents a result.
    initial begin
        exp_t e;
        logic [3:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant", 8'(grant), 8'(e.grant));
                chk("owner", 8'(owner), 8'(e.owner));
                chk("busy", 8'(busy), 8'(e.busy));
                chk("err", 8'(err), 8'(e.err));
                chk("timeout", 8'(timeout), 8'(e.timeout));
            end
            if (grant != 0 && prev_grant == 0) order_q.push_back(int'(owner));
            prev_grant = grant;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        // Reset then quiet bus
        repeat (3) cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
        repeat (5) cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Single requestor tenure
        cyc(4'b0100, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0100, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0100, 1'b0);
        repeat (2) cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // All requesting, release two cycles after each grant
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        order_q.delete();
        for (int c = 0; c < 20; c++)
            cyc(4'b1111, 4'b0000, (m_busy && m_hold == 2) ? own_bit() : 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("order_len", 8'(order_q.size() >= 5), 8'd1);
        for (int i = 0; i < 5; i++)
            if (i < order_q.size()) chk("order", 8'(order_q[i]), 8'(exp_order[i]));
        // Wrong-index release while owner 1 holds
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b0010, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0010, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b1000, 1'b0);
        repeat (3) cyc(4'b0000, 4'b0010, 4'b0000, 1'b0);
        // Long hold, then release on the expiry cycle
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b0001, 4'b0000, 4'b0000, 1'b0);
        repeat (20) cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b0001, 4'b0000, 4'b0000, 1'b0);
        for (int c = 0; c < 18; c++)
            cyc(4'b0000, 4'b0000, (m_busy && m_hold == MAX_HOLD - 1) ? own_bit() : 4'b0000, 1'b0);
        // Reset during BUSY with req held
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 4'b0000, 1'b1);
        repeat (3) cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
        // Randomized traffic with occasional protocol errors
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] r, u, rl;
            r = 4'($urandom);
            u = '0;
            rl = '0;
            if (m_busy) begin
                if ($urandom_range(0, 4) == 0) rl = own_bit();
                else if ($urandom_range(0, 1) == 0) u = own_bit();
            end
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 0) u[$urandom_range(0, 3)] = 1'b1;
                else rl[$urandom_range(0, 3)] = 1'b1;
            end
            cyc(r, u, rl, (c % 90) == 0);
        end
        repeat (2) @(negedge clk);
        chk("drain", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/resource_granter.md
Name: resource_granter

Overview:
Multi-client granter for the req/grant/use/release resource protocol. It is the granting end for up to N requestor FSMs, each cycling Request -> Granted -> Use -> Done.
- Arbitrates round-robin among pending requests.
- Holds a level grant to exactly one owner until that owner pulses release.
- Flags protocol violations, so it serves as both the real granter and a checkable model for property monitors.

Parameters:
N, 4, number of requestors
IDW, 2, width of owner index (must equal ceil(log2(N)), N >= 2)
MAX_HOLD, 16, max BUSY cycles before forced revoke (only with GRANTER_TIMEOUT_EN)
HOLD_W, 5, hold counter width (must hold MAX_HOLD)

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high
req  input  N  req[i] high while requestor i waits for grant
use  input  N  use[i] high while requestor i is using the resource
release  input  N  release[i] one-cycle pulse ending requestor i's tenure
grant  output  N  one-hot or zero; grant[i] level while i owns the resource
owner  output  IDW  index of current/last owner
busy  output  1  high in BUSY state
err  output  1  sticky protocol-error flag
timeout  output  1  sticky forced-revoke flag (tied 0 without GRANTER_TIMEOUT_EN)

Behaviour:
- Reset (sync, sampled on posedge): state=IDLE, grant=0, owner=0, busy=0, err=0, timeout=0, rr_ptr=0, hold_cnt=0.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... N-1, 0, ...).
  - Next cycle: grant[sel]=1, owner=sel, busy=1, state=BUSY, rr_ptr=(sel+1) mod N, hold_cnt=0.
  - If req == 0, stay in IDLE.
  - Latency from req rising to grant rising is 1 cycle.
- BUSY:
  - On release[owner]=1: next cycle grant=0, busy=0, state=IDLE.
  - owner keeps the last value after release.
  - A new grant is issued no earlier than the cycle after IDLE is entered, so there is a minimum of one gap cycle with grant=0 between tenures.
- Grant is never withdrawn from an owner except by reset or timeout.
- req[i] dropping before grant is a withdrawal: legal, that requestor is simply not selected.
- req[owner] still high in BUSY is legal (requestor lag).
- err is set (sticky until reset) on any of:
  - release[j] or use[j] with j != owner, or either while in IDLE;
  - use[owner] and release[owner] both high in the same cycle;
  - more than one release bit high.
- Simultaneous release[owner] and a new req from others: release is honored, IDLE next cycle, arbitration the cycle after.
- Simultaneous release[owner] and an error condition on another index: both take effect.
- Reset mid-BUSY: grant drops at the next posedge; rr_ptr returns to 0.

Optional Feature:
GRANTER_TIMEOUT_EN
- Defined:
  - hold_cnt increments every BUSY cycle (saturating).
  - If hold_cnt reaches MAX_HOLD with no release[owner], force grant=0 and state=IDLE next cycle, and set timeout (sticky).
  - A release arriving in the same cycle as expiry counts as a normal release; timeout is not set.
- Undefined: no counter logic; timeout tied 0; the owner may hold indefinitely.

Decomposition:
- Shared package: granter state enum {IDLE, BUSY} (named distinctly from the requestor's R/G/U/D and I/B enums) and a one-hot-to-index function.
- Sub-module: rr_arbiter (req, rr_ptr -> sel index, valid). It is combinational and instantiated once; it is reusable by other arbiters in the design.

Test Plan:
- reset 3 cycles, req=4'b0000 for 5 cycles -> grant=0, busy=0, err=0 throughout.
- req=4'b0100 at cycle t -> grant=4'b0100, owner=2 at t+1; drop req, use[2] 2 cycles, release[2] at t+4 -> grant=0 at t+5.
- req=4'b1111 held, each owner releases 2 cycles after grant -> grant order 0,1,2,3,0 with a one-cycle grant=0 gap between tenures.
- owner=1 in BUSY, pulse release[3] -> err=1 next cycle and stays 1; grant=4'b0010 unchanged.
- GRANTER_TIMEOUT_EN, MAX_HOLD=16, owner never releases -> grant=0 and timeout=1 exactly 16 BUSY cycles after grant rose; a second run releasing on the expiry cycle -> timeout stays 0.
- Assert reset during BUSY with req=4'b1000 -> grant=0 next cycle; after reset is deasserted, grant=4'b1000 one cycle later.
